// File: rtl/ora_misr.sv
// Output response analyser: two parallel MISRs compact CUT and reference beats
// per window; a one-cycle ORA_RES pulse flags a signature mismatch at window close.
module ora_misr #(
  parameter int                 WIDTH    = 8,
  parameter int                 SIG_BITS = 16,
  parameter logic [SIG_BITS-1:0] POLY    = 16'h1021,
  parameter logic [SIG_BITS-1:0] SEED    = 16'hFFFF,
  parameter int                 WINDOW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    CUT_OUT,
  input  logic [WIDTH-1:0]    REF_OUT,
  input  logic                VALID,
  output logic                READY,
  input  logic                TPG_END,
  output logic                ORA_RES,
  output logic                WIN_DONE,
  output logic [SIG_BITS-1:0] SIG
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CMP  = 2'd2
  } state_t;

  state_t              state_reg;
  logic [SIG_BITS-1:0] cut_misr_reg;
  logic [SIG_BITS-1:0] ref_misr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [SIG_BITS-1:0] sig_reg;
  logic                ora_res_reg;
  logic                win_done_reg;

  logic                accept;
  logic [SIG_BITS-1:0] cut_misr_next;
  logic [SIG_BITS-1:0] ref_misr_next;

  function automatic logic [SIG_BITS-1:0] misr_step(
    input logic [SIG_BITS-1:0] m,
    input logic [WIDTH-1:0]    d
  );
    logic [SIG_BITS-1:0] ext;
    ext = '0;
    ext[WIDTH-1:0] = d;
    return {m[SIG_BITS-2:0], 1'b0} ^ (m[SIG_BITS-1] ? POLY : '0) ^ ext;
  endfunction

  assign READY         = (state_reg != CMP);
  assign accept        = VALID && READY;
  assign cut_misr_next = misr_step(cut_misr_reg, CUT_OUT);
  assign ref_misr_next = misr_step(ref_misr_reg, REF_OUT);

  assign ORA_RES  = ora_res_reg;
  assign WIN_DONE = win_done_reg;
  assign SIG      = sig_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cut_misr_reg <= SEED;
      ref_misr_reg <= SEED;
      count_reg    <= '0;
      sig_reg      <= SEED;
      ora_res_reg  <= 1'b0;
      win_done_reg <= 1'b0;
    end else begin
      ora_res_reg  <= 1'b0;
      win_done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          // A lone TPG_END with no open window has nothing to close.
          if (accept) begin
            cut_misr_reg <= cut_misr_next;
            ref_misr_reg <= ref_misr_next;
            count_reg    <= CNT_W'(1);
            state_reg    <= TPG_END ? CMP : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            cut_misr_reg <= cut_misr_next;
            ref_misr_reg <= ref_misr_next;
            count_reg    <= count_reg + CNT_W'(1);
            // count holds beats before this one, so WINDOW-1 means this beat fills it
            if (count_reg == LAST_CNT || TPG_END) begin
              state_reg <= CMP;
            end
          end else if (TPG_END) begin
            state_reg <= CMP;
          end
        end
        CMP: begin
          win_done_reg <= 1'b1;
          ora_res_reg  <= (cut_misr_reg != ref_misr_reg);
          sig_reg      <= cut_misr_reg;
          cut_misr_reg <= SEED;
          ref_misr_reg <= SEED;
          count_reg    <= '0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ora_misr.sv
// Directed bench for ora_misr: stimulus feeds a reference MISR model whose window
// results are queued and popped when WIN_DONE pulses.
module tb_ora_misr;
  localparam int          WIDTH    = 8;
  localparam int          SIG_BITS = 16;
  localparam int          WINDOW   = 16;
  localparam logic [15:0] POLY     = 16'h1021;
  localparam logic [15:0] SEED     = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cut_out = '0;
  logic [7:0]  ref_out = '0;
  logic        valid = 1'b0;
  logic        tpg_end = 1'b0;
  logic        ready;
  logic        ora_res;
  logic        win_done;
  logic [15:0] sig;

  always #5 clk = ~clk;

  ora_misr #(
    .WIDTH(WIDTH), .SIG_BITS(SIG_BITS), .POLY(POLY), .SEED(SEED), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .rst(rst), .CUT_OUT(cut_out), .REF_OUT(ref_out), .VALID(valid),
    .READY(ready), .TPG_END(tpg_end), .ORA_RES(ora_res), .WIN_DONE(win_done), .SIG(sig)
  );

  typedef struct packed {
    logic [15:0] sig;
    logic        ora;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          ora_pulses = 0;
  int          win_pulses = 0;
  logic [15:0] m_cut = SEED;
  logic [15:0] m_ref = SEED;
  int          m_cnt = 0;

  function automatic logic [15:0] step(input logic [15:0] m, input logic [7:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? POLY : 16'h0000) ^ {8'h00, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic close_window();
    exp_t e;
    e.sig = m_cut;
    e.ora = (m_cut != m_ref);
    sb.push_back(e);
    m_cut = SEED;
    m_ref = SEED;
    m_cnt = 0;
  endtask

  // Presents a beat and holds it until the DUT is ready; acceptance happens at the next rising edge.
  task automatic send(input logic [7:0] c, input logic [7:0] r, input logic te);
    int guard;
    guard = 0;
    @(negedge clk);
    valid = 1'b1; cut_out = c; ref_out = r; tpg_end = te;
    while (ready !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (ready !== 1'b1) begin
      check("ready_timeout", {31'b0, ready}, 1);
    end else begin
      m_cut = step(m_cut, c);
      m_ref = step(m_ref, r);
      m_cnt++;
      if (m_cnt == WINDOW || te) close_window();
    end
  endtask

  task automatic end_only();
    @(negedge clk);
    valid = 1'b0; tpg_end = 1'b1;
    if (m_cnt > 0) close_window();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0; tpg_end = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (win_done === 1'b1) begin
      win_pulses++;
      if (ora_res === 1'b1) ora_pulses++;
      if (sb.size() == 0) begin
        check("unexpected_win_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sig", {16'b0, sig}, {16'b0, e.sig});
        check("ora_res", {31'b0, ora_res}, {31'b0, e.ora});
      end
    end
    if (ora_res === 1'b1) check("ora_needs_win_done", {31'b0, win_done}, 1);
  end

  initial begin
    int p_ora;
    int p_win;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'b0, ready}, 1);
    check("rst_sig", {16'b0, sig}, {16'b0, SEED});
    check("rst_ora", {31'b0, ora_res}, 0);
    check("rst_win_done", {31'b0, win_done}, 0);

    // Clean full window, READY drops for exactly the CMP cycle
    p_ora = ora_pulses; p_win = win_pulses;
    for (int i = 0; i < 16; i++) send(8'(i), 8'(i), 1'b0);
    @(negedge clk);
    valid = 1'b0;
    check("ready_in_cmp", {31'b0, ready}, 0);
    @(negedge clk);
    check("ready_after_cmp", {31'b0, ready}, 1);
    idle(2);
    check("t1_win_count", win_pulses - p_win, 1);
    check("t1_ora_count", ora_pulses - p_ora, 0);

    // Single corrupted beat
    p_ora = ora_pulses; p_win = win_pulses;
    for (int i = 0; i < 16; i++) send((i == 3) ? (8'(i) ^ 8'h04) : 8'(i), 8'(i), 1'b0);
    idle(3);
    check("t2_win_count", win_pulses - p_win, 1);
    check("t2_ora_count", ora_pulses - p_ora, 1);

    // Early close on the first beat
    send(8'h00, 8'h00, 1'b1);
    idle(3);
    check("t3_sig_const", {16'b0, sig}, 32'h0000EFDF);
    check("t3_ora", {31'b0, ora_res}, 0);

    // Partial window closed by TPG_END alone
    p_win = win_pulses;
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 8'(8'h30 + i), 1'b0);
    end_only();
    idle(3);
    check("t4_win_count", win_pulses - p_win, 1);

    // Lone TPG_END in IDLE is ignored
    p_win = win_pulses;
    end_only();
    idle(3);
    check("idle_tpg_end_win_count", win_pulses - p_win, 0);

    // VALID held through CMP, back-to-back windows
    p_win = win_pulses;
    for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)), 8'(0), 1'b0) ;
    idle(3);
    p_win = win_pulses;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      send(d, d, (i == 19));
    end
    idle(3);
    check("t5_win_count", win_pulses - p_win, 2);

    // Reset mid-window discards it
    p_ora = ora_pulses; p_win = win_pulses;
    for (int i = 0; i < 7; i++) send(8'(i) ^ 8'h55, 8'(i), 1'b0);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; tpg_end = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_cut = SEED; m_ref = SEED; m_cnt = 0;
    check("t6_sig_after_rst", {16'b0, sig}, {16'b0, SEED});
    check("t6_ready_after_rst", {31'b0, ready}, 1);
    idle(3);
    check("t6_no_win_done", win_pulses - p_win, 0);
    check("t6_no_ora", ora_pulses - p_ora, 0);
    for (int i = 0; i < 16; i++) send(8'(i * 3), 8'(i * 3), 1'b0);
    idle(3);
    check("t6_clean_win_count", win_pulses - p_win, 1);
    check("t6_clean_ora_count", ora_pulses - p_ora, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ora_misr.md
# ora_misr

Output response analyser for the BIST loop. It sits downstream of the circuit under test (CUT) and the golden reference model, and upstream of the BIST controller, which consumes its `ORA_RES` output. Each accepted response beat is compacted into two parallel MISRs, one fed by the CUT and one by the reference model. At the end of every window of `WINDOW` beats, or early on `TPG_END`, the two signatures are compared and a mismatch raises a one-cycle `ORA_RES` pulse.

## Interface
Parameters:
- `WIDTH`, 8: CUT/reference response width; must be ≤ `SIG_BITS`.
- `SIG_BITS`, 16: MISR width.
- `POLY`, 16'h1021: MISR feedback polynomial, `SIG_BITS` wide.
- `SEED`, 16'hFFFF: MISR initial/reseed value.
- `WINDOW`, 16: beats per compaction window; must be ≥ 2.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `CUT_OUT`, input, `WIDTH`: CUT response beat.
- `REF_OUT`, input, `WIDTH`: golden model response for the same pattern.
- `VALID`, input, 1: `CUT_OUT`/`REF_OUT` carry a beat this cycle.
- `READY`, output, 1: the block accepts a beat this cycle.
- `TPG_END`, input, 1: the pattern generator has issued its last pattern.
- `ORA_RES`, output, 1: one-cycle pulse meaning the window signatures differ.
- `WIN_DONE`, output, 1: one-cycle pulse on every window close.
- `SIG`, output, `SIG_BITS`: CUT signature captured at the last window close.

## Operation
- A beat is accepted when `VALID && READY`. `READY` = (state != CMP), decoded combinationally from state.
- MISR update on an accepted beat: `m_next = {m[SIG_BITS-2:0],1'b0} ^ (m[SIG_BITS-1] ? POLY : 0) ^ zero_extend(data)`. The CUT MISR takes `CUT_OUT`; the reference MISR takes `REF_OUT`.
- Beat counter width is `$clog2(WINDOW)`. It counts accepted beats in the current window.
- States:
  - IDLE: both MISRs = `SEED`, beat count = 0. An accepted beat absorbs, sets count to 1, and goes to ACC. `TPG_END` without an accepted beat is ignored.
  - ACC: an accepted beat absorbs and increments count. The window closes to CMP when either:
    - count reaches `WINDOW` on this beat, or
    - this beat is accepted with `TPG_END` = 1.
  - ACC, early close: `TPG_END` = 1 with no accepted beat closes the partial window to CMP without absorbing.
  - CMP (one cycle): compares the two MISRs and captures the CUT MISR into `SIG`. It then reseeds both MISRs to `SEED`, clears count, and returns to IDLE. `VALID` is not accepted here; the source must hold its beat.
- `ORA_RES` and `WIN_DONE` are registered outputs.
- Reset values: state IDLE, both MISRs `SEED`, count 0, `SIG` = `SEED`, `ORA_RES` 0, `WIN_DONE` 0. `READY` is 1 from the first cycle after `rst` is sampled.
- `rst` mid-window discards the partial window with no compare and no pulse.

## Timing
- Closing beat accepted in cycle N (state ACC) → CMP in N+1 → `WIN_DONE`, `ORA_RES` (on mismatch) and the new `SIG` are visible in N+2. State returns to IDLE in N+2.
- `READY` is 0 only in cycle N+1 (the CMP cycle). Sustained throughput is `WINDOW` beats per `WINDOW`+1 cycles.
- A beat accepted in N+2 starts the next window against freshly seeded MISRs.
- `TPG_END` and the `WINDOW`-th beat in the same cycle produce one close, not two.
- `ORA_RES` never asserts without `WIN_DONE` in the same cycle.

## Test plan
- Reset, then 16 beats with `CUT_OUT` = `REF_OUT` = 0..15, `VALID` held high → one `WIN_DONE` pulse, `ORA_RES` stays 0, `READY` low for exactly 1 cycle after beat 16.
- Same as above but `CUT_OUT` = `REF_OUT` ^ 8'h04 on beat 3 only → `ORA_RES` = 1 for exactly one cycle, coincident with `WIN_DONE`.
- Single beat of 8'h00 on both inputs with `TPG_END` = 1 → window closes early, `SIG` = 16'hEFDF, `ORA_RES` = 0.
- 5 matched beats, then `TPG_END` alone with `VALID` = 0 → a partial window of 5 closes, `WIN_DONE` pulses once, and `SIG` equals the model MISR over 5 beats.
- `VALID` held high through CMP with the beat held → the beat is accepted in the first IDLE cycle after CMP, no beat is lost or duplicated, and the next window's `SIG` matches the model.
- `rst` asserted after 7 beats of a mismatching window → no `ORA_RES` or `WIN_DONE`, `SIG` = 16'hFFFF, and a following clean 16-beat window yields `ORA_RES` = 0.
